// File: rtl/matinv_pkg.sv
// matinv_pkg: shared state encoding and sizing constants for the matrix-inversion load sequencer
package matinv_pkg;
  localparam int NBYTES_C = 18;
  localparam int CW = $clog2(NBYTES_C);
  localparam int TMO_CYC_DEF = 1024;
  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, STREAM, WAIT_SP, RUN, WAIT_INV, REPORT} state_t;
endpackage

// File: rtl/matinv_frame_buf.sv
// matinv_frame_buf: one-frame byte store with a synchronous write port and combinational read port
module matinv_frame_buf import matinv_pkg::*; #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [CW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [NBYTES_C];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/matinv_load_sequencer.sv
// matinv_load_sequencer: buffers an 18-byte frame, streams it gap-free into the loader, then runs the inverter.
module matinv_load_sequencer import matinv_pkg::*; #(
  parameter int DW = 8,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          sp_start,
  output logic [DW-1:0] sp_serial_in,
  input  logic          sp_done,
  output logic          inv_start,
  input  logic          inv_done,
  output logic          busy,
  output logic          frame_done,
  output logic          err
);
  localparam logic [CW-1:0] LAST = CW'(NBYTES_C - 1);
  state_t state, next;
  logic [CW-1:0] cnt, idx;
  logic [DW-1:0] rd_data;
  logic wr_en, tmo_hit;
`ifdef MATINV_SEQ_TMO_EN
  localparam int TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] tmo;
  logic in_wait;
  assign in_wait = state == WAIT_SP || state == WAIT_INV;
  assign tmo_hit = in_wait && tmo == TW'(TMO_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo <= '0;
      err <= 1'b0;
    end else begin
      tmo <= (in_wait && next == state) ? tmo + 1'b1 : '0;
      if (tmo_hit && next == IDLE) err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= next;
      if (wr_en) cnt <= state == IDLE ? CW'(1) : cnt + 1'b1;
      idx <= state == STREAM ? idx + 1'b1 : '0;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = s_valid ? FILL : IDLE;
      FILL:     next = (s_valid && cnt == LAST) ? LAUNCH : FILL;
      LAUNCH:   next = STREAM;
      STREAM:   next = idx == LAST ? WAIT_SP : STREAM;
      WAIT_SP:  next = sp_done ? RUN : tmo_hit ? IDLE : WAIT_SP;
      RUN:      next = WAIT_INV;
      WAIT_INV: next = inv_done ? REPORT : tmo_hit ? IDLE : WAIT_INV;
      REPORT:   next = IDLE;
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == IDLE || state == FILL;
    sp_start = state == LAUNCH;
    sp_serial_in = state == STREAM ? rd_data : '0;
    inv_start = state == RUN;
    busy = state != IDLE;
    frame_done = state == REPORT;
  end
  assign wr_en = s_valid && s_ready;
  matinv_frame_buf #(.DW(DW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (state == IDLE ? '0 : cnt),
    .wr_data (s_data),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_matinv_load_sequencer.sv
// tb_matinv_load_sequencer: directed bench with loader/inverter models and a byte scoreboard
module tb_matinv_load_sequencer;
  localparam int NB = 18;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready, sp_start, inv_start, busy, frame_done, err;
  logic [7:0] sp_serial_in;
  logic sp_done_m = 1'b0, sp_done_x = 1'b0, inv_done_m = 1'b0, inv_done_x = 1'b0;
  logic sp_done, inv_done;
  int npass = 0, nfail = 0, ntotal = 0;
  logic [7:0] exp_q[$];
  logic [7:0] lbuf [NB];
  logic [15:0] a_in = '0, i_in = '0;
  logic [8:0] lm_e;
  bit lm_ok;
  int inv_lat = 40;
  bit inv_hold = 0, in_frame = 0;
  int rdy_viol = 0, fd_cnt = 0, exp_fd = 0, n, fd_save;

  assign sp_done = sp_done_m | sp_done_x;
  assign inv_done = inv_done_m | inv_done_x;
  always #5 clk = ~clk;

  matinv_load_sequencer #(.TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sp_start(sp_start), .sp_serial_in(sp_serial_in), .sp_done(sp_done),
    .inv_start(inv_start), .inv_done(inv_done), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int w = 0;
    if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    s_data = b;
    s_valid = 1'b1;
    while (!s_ready && w < 400) begin @(posedge clk); #1; w++; end
    chk("s_ready_accept", 32'(s_ready), 1);
    @(posedge clk); #1;
    exp_q.push_back(b);
    s_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int w = 0;
    do begin @(negedge clk); w++; end while (frame_done !== 1'b1 && w < 400);
    chk("frame_done_seen", 32'(frame_done), 1);
    exp_fd++;
  endtask

  initial forever begin
    @(negedge clk);
    if (sp_start === 1'b1 && !rst) begin
      lm_ok = 1;
      for (int i = 0; i < NB; i++) begin
        @(negedge clk);
        if (rst) begin lm_ok = 0; break; end
        lm_e = exp_q.size() > 0 ? {1'b0, exp_q.pop_front()} : 9'h1ff;
        chk("sp_serial_in", 32'(sp_serial_in), 32'(lm_e));
        lbuf[i] = sp_serial_in;
      end
      if (lm_ok) begin
        a_in = {lbuf[0], lbuf[1]};
        i_in = {lbuf[16], lbuf[17]};
        @(posedge clk);
        @(posedge clk); #1;
        sp_done_m = 1'b1;
        @(posedge clk); #1;
        sp_done_m = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (inv_start === 1'b1 && !inv_hold) begin
      repeat (inv_lat) @(posedge clk);
      #1 inv_done_m = 1'b1;
      @(posedge clk); #1;
      inv_done_m = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sp_done_m) begin
      @(negedge clk);
      chk("inv_start_after_sp_done", 32'(inv_start), 1);
    end
    if (inv_done_m) begin
      @(negedge clk);
      chk("frame_done_after_inv_done", 32'(frame_done), 1);
      @(negedge clk);
      chk("busy_drop", 32'(busy), 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst || !busy) in_frame = 0;
    else if (sp_start) in_frame = 1;
    if (in_frame && s_ready) rdy_viol++;
    if (frame_done) begin in_frame = 0; fd_cnt++; end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({busy, sp_start, inv_start, frame_done, err, sp_serial_in}), 0);
    chk("reset_s_ready", 32'(s_ready), 1);
    rst = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(8'(i + 1), 0);
    chk("sp_start_after_last", 32'(sp_start), 1);
    chk("s_ready_launch", 32'(s_ready), 0);
    wait_frame();
    chk("a_in_f1", 32'(a_in), 32'h0102);
    chk("i_in_f1", 32'(i_in), 32'h1112);
    for (int i = 0; i < NB; i++) send_byte(8'(i + 1), 3);
    for (int i = 0; i < NB; i++) send_byte(8'(8'hA0 + i), 0);
    exp_fd++;
    wait_frame();
    chk("a_in_f3", 32'(a_in), 32'hA0A1);
    chk("i_in_f3", 32'(i_in), 32'hB0B1);
    for (int i = 0; i < NB; i++) send_byte(8'(8'h30 + i), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("stream_idx7", 32'(sp_serial_in), 32'h37);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outs", 32'({busy, sp_start, inv_start, frame_done, err, sp_serial_in}), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) send_byte(8'(8'h40 + i), 0);
    wait_frame();
    chk("a_in_f4", 32'(a_in), 32'h4041);
    chk("i_in_f4", 32'(i_in), 32'h5051);
    @(posedge clk); #1;
    sp_done_x = 1'b1; inv_done_x = 1'b1;
    @(posedge clk); #1;
    sp_done_x = 1'b0; inv_done_x = 1'b0;
    chk("spur_idle_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 0);
    sp_done_x = 1'b1; inv_done_x = 1'b1;
    @(posedge clk); #1;
    sp_done_x = 1'b0; inv_done_x = 1'b0;
    chk("spur_fill_state", 32'({busy, s_ready}), 32'b11);
    for (int i = 5; i < NB; i++) send_byte(8'(8'h60 + i), 0);
    chk("spur_sp_start", 32'(sp_start), 1);
    wait_frame();
    chk("a_in_f5", 32'(a_in), 32'h6061);
    chk("i_in_f5", 32'(i_in), 32'h7071);
`ifdef MATINV_SEQ_TMO_EN
    inv_hold = 1;
    fd_save = fd_cnt;
    for (int i = 0; i < NB; i++) send_byte(8'(8'h80 + i), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (inv_start !== 1'b1 && n < 200);
    chk("tmo_inv_start", 32'(inv_start), 1);
    n = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("tmo_cycles", 32'(n), 16);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_no_frame_done", 32'(fd_cnt), 32'(fd_save));
    inv_hold = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) send_byte(8'(8'h90 + i), 0);
    wait_frame();
    chk("err_sticky", 32'(err), 1);
    chk("a_in_f7", 32'(a_in), 32'h9091);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", 32'(err), 0);
`else
    chk("err_tied_low", 32'(err), 0);
`endif
    repeat (3) @(negedge clk);
    chk("frame_count", 32'(fd_cnt), 32'(exp_fd));
    chk("s_ready_low_in_frame", 32'(rdy_viol), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
